// File: rtl/esaxi_pkg.sv
// Shared types and constants for the Epiphany AXI-Lite to mi_* bridge.
package esaxi_pkg;

  localparam int MI_AW = 16;
  localparam int MI_DW = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    WACK  = 4'd1,
    WMEM  = 4'd2,
    BRESP = 4'd3,
    RACK  = 4'd4,
    RMEM  = 4'd5,
    RPIPE = 4'd6,
    RCAP  = 4'd7,
    RRESP = 4'd8
  } state_e;

endpackage

// File: rtl/esaxi_rr_arb.sv
// Two-requester round-robin arbiter (write vs read); resets to write priority.
module esaxi_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_w,
  input  logic req_r,
  output logic gnt_w,
  output logic gnt_r
);

  logic prio_w;

  always_comb begin
    gnt_w = en & req_w & (~req_r | prio_w);
    gnt_r = en & req_r & ~gnt_w;
  end

  // After a read grant writes win the next conflict, and vice versa.
  always_ff @(posedge clk) begin
    if (!rst_n)              prio_w <= 1'b1;
    else if (gnt_w | gnt_r)  prio_w <= gnt_r;
  end

endmodule

// File: rtl/esaxi_mi_ctrl.sv
// AXI4-Lite slave sequencing the mi_* register-file interface, one transaction at a time.
// Define ESAXI_MI_RDREG_EN for RAMs with registered outputs (adds the RPIPE wait state).
module esaxi_mi_ctrl
  import esaxi_pkg::*;
#(
  parameter int RFAW = 13
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic [MI_AW-1:0]     s_axi_awaddr,
  input  logic [2:0]           s_axi_awprot,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [MI_DW-1:0]     s_axi_wdata,
  input  logic [MI_DW/8-1:0]   s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [MI_AW-1:0]     s_axi_araddr,
  input  logic [2:0]           s_axi_arprot,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [MI_DW-1:0]     s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic                 mi_clk,
  output logic                 mi_en,
  output logic [MI_DW/8-1:0]   mi_we,
  output logic [MI_AW-1:0]     mi_addr,
  output logic [MI_DW-1:0]     mi_din,
  input  logic [MI_DW-1:0]     mi_rd_data
);

  // Word-aligned and limited to the decoded register space.
  localparam logic [MI_AW-1:0] ADDR_MASK =
    MI_AW'((32'd1 << RFAW) - 32'd1) & ~MI_AW'(3);

`ifdef ESAXI_MI_RDREG_EN
  localparam state_e RD_NEXT = RPIPE;
`else
  localparam state_e RD_NEXT = RCAP;
`endif

  state_e               state, state_nxt;
  logic                 gnt_w, gnt_r;
  logic [MI_AW-1:0]     addr_q;
  logic [MI_DW-1:0]     din_q;
  logic [MI_DW/8-1:0]   we_q;
  logic [MI_DW-1:0]     rdata_q;

  logic unused_prot;
  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  esaxi_rr_arb u_arb (
    .clk   (s_axi_aclk),
    .rst_n (s_axi_aresetn),
    .en    (state == IDLE),
    .req_w (s_axi_awvalid & s_axi_wvalid),
    .req_r (s_axi_arvalid),
    .gnt_w (gnt_w),
    .gnt_r (gnt_r)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (gnt_w)      state_nxt = WACK;
             else if (gnt_r) state_nxt = RACK;
      WACK:  state_nxt = WMEM;
      WMEM:  state_nxt = BRESP;
      BRESP: if (s_axi_bready) state_nxt = IDLE;
      RACK:  state_nxt = RMEM;
      RMEM:  state_nxt = RD_NEXT;
      RPIPE: state_nxt = RCAP;
      RCAP:  state_nxt = RRESP;
      RRESP: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mi_* payload only moves on an address/data capture; rdata only in RCAP.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (state == WACK) begin
        addr_q <= s_axi_awaddr & ADDR_MASK;
        din_q  <= s_axi_wdata;
        we_q   <= s_axi_wstrb;
      end
      if (state == RACK) addr_q  <= s_axi_araddr & ADDR_MASK;
      if (state == RCAP) rdata_q <= mi_rd_data;
    end
  end

  assign s_axi_awready = (state == WACK);
  assign s_axi_wready  = (state == WACK);
  assign s_axi_arready = (state == RACK);
  assign s_axi_bvalid  = (state == BRESP);
  assign s_axi_rvalid  = (state == RRESP);
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rdata   = rdata_q;

  assign mi_clk  = s_axi_aclk;
  assign mi_en   = (state == WMEM) | (state == RMEM);
  assign mi_we   = (state == WMEM) ? we_q : '0;
  assign mi_addr = addr_q;
  assign mi_din  = din_q;

endmodule

// File: tb/tb_esaxi_mi_ctrl.sv
// Scoreboard bench for esaxi_mi_ctrl: directed cases plus randomized traffic against a word-array model.
module tb_esaxi_mi_ctrl;

  localparam int RFAW = 13;
`ifdef ESAXI_MI_RDREG_EN
  localparam int RL = 5;
`else
  localparam int RL = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, mi_clk, mi_en;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, mi_din, mi_rd_data;
  logic [3:0]  mi_we;
  logic [15:0] mi_addr;

  esaxi_mi_ctrl #(.RFAW(RFAW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mi_clk(mi_clk), .mi_en(mi_en), .mi_we(mi_we), .mi_addr(mi_addr), .mi_din(mi_din),
    .mi_rd_data(mi_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file RAM seen by the mi port (1 or 2 cycle read latency).
  logic [31:0] ram [0:16383];
  logic [31:0] rd1 = '0, rd2 = '0, ram_w;
  always @(posedge clk) begin
    if (mi_en) begin
      ram_w = ram[mi_addr[15:2]];
      for (int b = 0; b < 4; b++) if (mi_we[b]) ram_w[8*b +: 8] = mi_din[8*b +: 8];
      ram[mi_addr[15:2]] <= ram_w;
      rd1 <= ram[mi_addr[15:2]];
    end
    rd2 <= rd1;
  end
  assign mi_rd_data = (RL == 5) ? rd2 : rd1;

  // Reference model: 2^RFAW bytes of word storage; upper address bits alias.
  logic [31:0] ref_mem [0:2047];

  typedef struct {
    bit          is_wr;
    int          acc;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic push_exp(bit is_wr, logic [15:0] a, logic [31:0] d, logic [3:0] s, int acc);
    exp_t e;
    int idx;
    idx     = (int'(a) / 4) % 2048;
    e.is_wr = is_wr;
    e.acc   = acc;
    e.addr  = 16'(idx * 4);
    e.strb  = is_wr ? s : 4'h0;
    if (is_wr) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      e.data = d;
    end else begin
      e.data = ref_mem[idx];
    end
    q.push_back(e);
  endtask

  // Monitor: pops the scoreboard as the DUT presents accepts, strobes and responses.
  int acc_seen = 0;
  bit resp_seen = 0;
  logic pv_r = 0, pr_r = 0, pv_b = 0, pr_b = 0;
  logic [31:0] p_rdata = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_r = 0; pv_b = 0; resp_seen = 0;
    end else begin
      if (pv_r) chk("rdata_hold", rdata, p_rdata);
      if (pv_r && !pr_r) chk("rvalid_hold", rvalid, 1);
      if (pv_b && !pr_b) chk("bvalid_hold", bvalid, 1);
      if (!mi_en) chk("mi_we_idle", mi_we, 0);
      if (awready || arready) begin
        chk("accept_while_resp", bvalid | rvalid, 0);
        chk("wready_eq_awready", wready, awready);
        if (q.size() == 0) chk("unexpected_accept", 1, 0);
        else begin
          chk("accept_kind", awready, q[0].is_wr);
          chk("accept_cycle", cyc, q[0].acc);
        end
        acc_seen = cyc; resp_seen = 0;
      end
      if (mi_en) begin
        if (q.size() == 0) chk("unexpected_mi_en", 1, 0);
        else begin
          chk("mi_en_cycle", cyc, acc_seen + 1);
          chk("mi_we", mi_we, q[0].strb);
          chk("mi_addr", mi_addr, q[0].addr);
          if (q[0].is_wr) chk("mi_din", mi_din, q[0].data);
        end
      end
      if ((bvalid || rvalid) && !resp_seen) begin
        if (q.size() == 0) chk("unexpected_resp", 1, 0);
        else if (bvalid) begin
          chk("bresp_kind", q[0].is_wr, 1);
          chk("bvalid_cycle", cyc, acc_seen + 2);
          chk("bresp", bresp, 0);
        end else begin
          chk("rresp_kind", q[0].is_wr, 0);
          chk("rvalid_cycle", cyc, acc_seen + RL - 1);
          chk("rdata", rdata, q[0].data);
          chk("rresp", rresp, 0);
        end
        resp_seen = 1;
      end
      if (((bvalid && bready) || (rvalid && rready)) && q.size() > 0) void'(q.pop_front());
      pv_r = rvalid; pr_r = rready; pv_b = bvalid; pr_b = bready; p_rdata = rdata;
    end
  end

  function automatic logic sig(int w);
    case (w)
      0:       return awready;
      1:       return arready;
      2:       return bvalid;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_sig(int w, string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sig(w) && n < 60);
    if (!sig(w)) chk(nm, 0, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_mi_en", mi_en, 0);
    chk("rst_mi_we", mi_we, 0);     chk("rst_mi_addr", mi_addr, 0);
    chk("rst_mi_din", mi_din, 0);   chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);     chk("rst_rresp", rresp, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); check_reset_vals();
    @(posedge clk); #1; rst_n = 1;
  endtask

  task automatic finish_b(int dly);
    wait_sig(2, "timeout_bvalid");
    repeat (dly) @(posedge clk);
    @(posedge clk); #1; bready = 1;
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic finish_r(int dly);
    wait_sig(3, "timeout_rvalid");
    repeat (dly) @(posedge clk);
    @(posedge clk); #1; rready = 1;
    @(posedge clk); #1; rready = 0;
  endtask

  task automatic do_write(logic [15:0] a, logic [31:0] d, logic [3:0] s, int wdly, int bdly);
    @(posedge clk); #1;
    awaddr = a; awvalid = 1;
    repeat (wdly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1;
    push_exp(1, a, d, s, cyc + 1);
    wait_sig(0, "timeout_awready");
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    finish_b(bdly);
  endtask

  task automatic do_read(logic [15:0] a, int rdly);
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    push_exp(0, a, 32'h0, 4'h0, cyc + 1);
    wait_sig(1, "timeout_arready");
    @(posedge clk); #1; arvalid = 0;
    finish_r(rdly);
  endtask

  // All three valids held; grants must alternate W,R,... starting with W.
  task automatic rr_phase();
    logic [15:0] wa [4];
    logic [31:0] wd [4];
    int a, wi, ri, n;
    bit saw_aw, saw_ar;
    for (int i = 0; i < 4; i++) begin
      wa[i] = 16'h0400 | 16'($urandom_range(0, 255) << 2);
      wd[i] = $urandom;
    end
    bready = 1; rready = 1;
    @(posedge clk); #1;
    awaddr = wa[0]; wdata = wd[0]; wstrb = 4'hF; araddr = wa[0];
    awvalid = 1; wvalid = 1; arvalid = 1;
    a = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      push_exp(1, wa[i], wd[i], 4'hF, a);      a += 4;
      push_exp(0, wa[i], 32'h0, 4'h0, a);      a += RL + 1;
    end
    wi = 0; ri = 0; n = 0;
    while ((wi < 4 || ri < 4) && n < 300) begin
      @(negedge clk); saw_aw = awready; saw_ar = arready;
      @(posedge clk); #1; n++;
      if (saw_aw) begin
        wi++;
        if (wi < 4) begin awaddr = wa[wi]; wdata = wd[wi]; end
        else begin awvalid = 0; wvalid = 0; end
      end
      if (saw_ar) begin
        ri++;
        if (ri < 4) araddr = wa[ri];
        else arvalid = 0;
      end
    end
    if (wi < 4 || ri < 4) chk("timeout_rr", 0, 1);
    n = 0;
    while (q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() > 0) chk("timeout_rr_drain", 0, 1);
    @(posedge clk); #1; bready = 0; rready = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wl [$];
    logic [15:0] a;
    int n;
    bit any;
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    ram[16'h0104 >> 2]     = 32'hDEAD_BEEF;
    ref_mem[16'h0104 >> 2] = 32'hDEAD_BEEF;

    apply_reset();
    rr_phase();

    apply_reset();
    do_read(16'h0104, 0);
    do_write(16'h0104, 32'h0000_1234, 4'hF, 0, 0);
    do_read(16'h0104, 1);

    // W held back by a late wvalid; upper address bits fold away.
    do_write(16'hE004, 32'hA5A5_0F0F, 4'hF, 5, 0);
    do_read(16'h0004, 0);
    do_write(16'h0008, 32'h1111_2222, 4'h0, 0, 2);
    do_read(16'h0008, 0);

    // rvalid held with rready low for 10 cycles while a write waits.
    @(posedge clk); #1;
    araddr = 16'h0104; arvalid = 1;
    push_exp(0, 16'h0104, 32'h0, 4'h0, cyc + 1);
    wait_sig(1, "timeout_arready");
    @(posedge clk); #1; arvalid = 0;
    wait_sig(3, "timeout_rvalid");
    @(posedge clk); #1;
    awaddr = 16'h0010; wdata = 32'hCAFE_F00D; wstrb = 4'h5; awvalid = 1; wvalid = 1;
    repeat (9) begin @(posedge clk); #1; end
    rready = 1;
    push_exp(1, 16'h0010, 32'hCAFE_F00D, 4'h5, cyc + 2);
    @(posedge clk); #1; rready = 0;
    wait_sig(0, "timeout_awready");
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    finish_b(0);
    do_read(16'h0010, 0);

    // Reset landing in RMEM drops the read silently.
    @(posedge clk); #1;
    araddr = 16'h0104; arvalid = 1;
    push_exp(0, 16'h0104, 32'h0, 4'h0, cyc + 1);
    wait_sig(1, "timeout_arready");
    @(posedge clk); #1; arvalid = 0;
    chk("mi_en_in_rmem", mi_en, 1);
    rst_n = 0; rready = 1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1; rst_n = 1;
    any = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (rvalid) any = 1; end
    chk("no_resp_after_reset", any, 0);
    @(posedge clk); #1; rready = 0;
    do_write(16'h0020, 32'h7654_3210, 4'hF, 0, 0);
    do_read(16'h0020, 0);

    // Randomized traffic; reads revisit written words through aliased upper bits.
    for (int i = 0; i < 40; i++) begin
      if (($urandom % 2) == 1 || wl.size() == 0) begin
        a = 16'($urandom);
        do_write(a, $urandom, 4'($urandom), int'($urandom % 3), int'($urandom % 3));
        wl.push_back(a);
      end else begin
        a = wl[$urandom % wl.size()] ^ {3'($urandom), 13'h0};
        do_read(a, int'($urandom % 3));
      end
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (q.size() > 0) chk("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
